// File: rtl/idle_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : idle_gate_ctrl_if
//  Purpose  : Control/status bundle between a gate controller and its user.
//  Revision : 1.0 - initial release
// ============================================================================
interface idle_gate_ctrl_if #(
    parameter int IDLE_W = 8,
    parameter int STAT_W = 16
);
    logic              test_en;
    logic              busy;
    logic [IDLE_W-1:0] idle_thresh;
    logic              wake_req;
    logic              wake_ack;
    logic              gate_en;
    logic              gated;
    logic              stat_clr;
    logic [STAT_W-1:0] gated_cycles;

    modport master (
        output test_en,
        output busy,
        output idle_thresh,
        output wake_req,
        output stat_clr,
        input  wake_ack,
        input  gate_en,
        input  gated,
        input  gated_cycles
    );

    modport slave (
        input  test_en,
        input  busy,
        input  idle_thresh,
        input  wake_req,
        input  stat_clr,
        output wake_ack,
        output gate_en,
        output gated,
        output gated_cycles
    );
endinterface
`default_nettype wire

// File: rtl/idle_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : idle_gate_ctrl
//  Purpose  : Closes a clock-gate enable after a run of idle cycles, reopens
//             it on activity or a four-phase wake request.
//  Revision : 1.0 - initial release
// ============================================================================
module idle_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2,
    parameter int STAT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    idle_gate_ctrl_if.slave bus
);

    localparam int                  c_WAKE_W    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [c_WAKE_W-1:0] c_WAKE_LOAD = c_WAKE_W'(WAKE_CYC - 1);
    localparam logic [IDLE_W-1:0]   c_IDLE_MAX  = '1;
    localparam logic [STAT_W-1:0]   c_STAT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [c_WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                gate_en_q, gate_en_d;
    logic                gated_q, gated_d;
    logic                wake_ack_q, wake_ack_d;
    logic [STAT_W-1:0]   gated_cycles_q, gated_cycles_d;

    logic                w_idle;
    logic [IDLE_W:0]     w_idle_next;
    logic                w_thresh_hit;

    assign w_idle       = !bus.busy && !bus.wake_req;
    // One bit wider so a saturated count still compares correctly.
    assign w_idle_next  = {1'b0, idle_cnt_q} + {{IDLE_W{1'b0}}, 1'b1};
    assign w_thresh_hit = (bus.idle_thresh != '0) &&
                          (w_idle_next >= {1'b0, bus.idle_thresh});

    always_comb begin : p_fsm
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (!w_idle) begin
                    idle_cnt_d = '0;
                end else if (w_thresh_hit) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != c_IDLE_MAX) begin
                    idle_cnt_d = w_idle_next[IDLE_W-1:0];
                end
            end
            ST_GATED: begin
                idle_cnt_d = '0;
                if (bus.busy || bus.wake_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = c_WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // busy is deliberately ignored here; WAKE length is fixed.
                idle_cnt_d = '0;
                if (wake_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_ACTIVE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_comb begin : p_out
        gate_en_d      = (state_d != ST_GATED);
        gated_d        = (state_d == ST_GATED);
        wake_ack_d     = (state_q == ST_ACTIVE) && bus.wake_req;
        gated_cycles_d = gated_cycles_q;
        if (bus.stat_clr) begin
            gated_cycles_d = '0;
        end else if ((state_q == ST_GATED) && (gated_cycles_q != c_STAT_MAX)) begin
            gated_cycles_d = gated_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q        <= ST_ACTIVE;
            idle_cnt_q     <= '0;
            wake_cnt_q     <= '0;
            gate_en_q      <= 1'b1;
            gated_q        <= 1'b0;
            wake_ack_q     <= 1'b0;
            gated_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            wake_cnt_q     <= wake_cnt_d;
            gate_en_q      <= gate_en_d;
            gated_q        <= gated_d;
            wake_ack_q     <= wake_ack_d;
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign bus.gate_en      = gate_en_q | bus.test_en;
    assign bus.gated        = gated_q;
    assign bus.wake_ack     = wake_ack_q;
    assign bus.gated_cycles = gated_cycles_q;

`ifndef SYNTHESIS
    a_gated_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        gated_q == (state_q == ST_GATED));
    a_gate_en_q_inverse: assert property (@(posedge clk) disable iff (!rst_n)
        gate_en_q == !gated_q);
    a_test_en_opens: assert property (@(posedge clk) disable iff (!rst_n)
        bus.test_en |-> bus.gate_en);
`endif

endmodule
`default_nettype wire

// File: tb/tb_idle_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idle_gate_ctrl
//  Purpose  : Self-checking bench for idle_gate_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idle_gate_ctrl;

    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int STAT_W   = 6;
    localparam int IDLE_MAX = (1 << IDLE_W) - 1;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
    localparam int M_ACT    = 0;
    localparam int M_GAT    = 1;
    localparam int M_WAKE   = 2;
    localparam int N_VEC    = 22;

    logic clk;
    logic rst_n;

    idle_gate_ctrl_if #(.IDLE_W(IDLE_W), .STAT_W(STAT_W)) bus ();

    idle_gate_ctrl #(
        .IDLE_W  (IDLE_W),
        .WAKE_CYC(WAKE_CYC),
        .STAT_W  (STAT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which phase the gate is in, how long the idle run is,
    // how many WAKE cycles remain, and the accounting counter.
    int m_mode, m_run, m_left, m_stat;
    bit m_ack;

    typedef struct {
        int busy; int wreq; int test; int clr; int thr;
        int e_gate; int e_gated; int e_ack; int e_stat;
    } vec_t;
    vec_t vt [N_VEC];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ACT; m_run = 0; m_left = 0; m_stat = 0; m_ack = 1'b0;
    endtask

    task automatic model_step();
        bit idle;
        idle  = !bus.busy && !bus.wake_req;
        m_ack = (m_mode == M_ACT) && bus.wake_req;
        if (bus.stat_clr)                           m_stat = 0;
        else if (m_mode == M_GAT && m_stat < STAT_MAX) m_stat = m_stat + 1;
        case (m_mode)
            M_ACT: begin
                if (!idle) m_run = 0;
                else if (bus.idle_thresh != 0 && m_run + 1 >= int'(bus.idle_thresh)) begin
                    m_mode = M_GAT; m_run = 0;
                end else m_run = (m_run + 1 > IDLE_MAX) ? IDLE_MAX : m_run + 1;
            end
            M_GAT: if (bus.busy || bus.wake_req) begin
                m_mode = M_WAKE; m_left = WAKE_CYC;
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_mode = M_ACT; m_run = 0; end
            end
        endcase
    endtask

    task automatic check_model();
        chk("model.gate_en", bus.gate_en, ((m_mode != M_GAT) || bus.test_en) ? 1 : 0);
        chk("model.gated", bus.gated, (m_mode == M_GAT) ? 1 : 0);
        chk("model.wake_ack", bus.wake_ack, m_ack);
        chk("model.gated_cycles", bus.gated_cycles, m_stat);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, ".gate_en"}, bus.gate_en, 1);
        chk({tag, ".gated"}, bus.gated, 0);
        chk({tag, ".wake_ack"}, bus.wake_ack, 0);
        chk({tag, ".gated_cycles"}, bus.gated_cycles, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int gated_seen;
        // busy wreq test clr thr | gate gated ack stat
        vt[0]  = '{0,0,0,0,4, 1,0,0,0};
        vt[1]  = '{0,0,0,0,4, 1,0,0,0};
        vt[2]  = '{0,0,0,0,4, 1,0,0,0};
        vt[3]  = '{0,0,0,0,4, 0,1,0,0};
        vt[4]  = '{0,0,0,0,4, 0,1,0,1};
        vt[5]  = '{0,0,0,0,4, 0,1,0,2};
        vt[6]  = '{1,0,0,0,4, 1,0,0,3};
        vt[7]  = '{0,0,0,0,4, 1,0,0,3};
        vt[8]  = '{0,0,0,0,4, 1,0,0,3};
        vt[9]  = '{0,0,0,0,4, 1,0,0,3};
        vt[10] = '{0,0,0,0,4, 1,0,0,3};
        vt[11] = '{0,0,0,0,4, 1,0,0,3};
        vt[12] = '{0,0,0,0,4, 0,1,0,3};
        vt[13] = '{0,0,1,0,4, 1,1,0,4};
        vt[14] = '{0,0,0,1,4, 0,1,0,0};
        vt[15] = '{0,0,0,0,4, 0,1,0,1};
        vt[16] = '{0,1,0,0,4, 1,0,0,2};
        vt[17] = '{0,1,0,0,4, 1,0,0,2};
        vt[18] = '{0,1,0,0,4, 1,0,0,2};
        vt[19] = '{0,1,0,0,4, 1,0,1,2};
        vt[20] = '{0,1,0,0,4, 1,0,1,2};
        vt[21] = '{0,0,0,0,4, 1,0,0,2};

        bus.busy = 1'b0; bus.wake_req = 1'b0; bus.test_en = 1'b0;
        bus.stat_clr = 1'b0; bus.idle_thresh = 8'd4;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("reset.gate_en", bus.gate_en, 1);
        chk("reset.gated", bus.gated, 0);
        chk("reset.wake_ack", bus.wake_ack, 0);
        chk("reset.gated_cycles", bus.gated_cycles, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            bus.busy        = vt[i].busy[0];
            bus.wake_req    = vt[i].wreq[0];
            bus.test_en     = vt[i].test[0];
            bus.stat_clr    = vt[i].clr[0];
            bus.idle_thresh = vt[i].thr[IDLE_W-1:0];
            tick();
            chk($sformatf("vec%0d.gate_en", i), bus.gate_en, vt[i].e_gate);
            chk($sformatf("vec%0d.gated", i), bus.gated, vt[i].e_gated);
            chk($sformatf("vec%0d.wake_ack", i), bus.wake_ack, vt[i].e_ack);
            chk($sformatf("vec%0d.gated_cycles", i), bus.gated_cycles, vt[i].e_stat);
        end

        // Lowering the threshold mid-count gates on the next idle edge.
        bus.busy = 1'b1; bus.idle_thresh = 8'd10;
        tick();
        bus.busy = 1'b0;
        repeat (5) tick();
        chk("thr_lower.before", bus.gated, 0);
        bus.idle_thresh = 8'd3;
        tick();
        chk("thr_lower.after", bus.gated, 1);

        // Threshold 0 never gates.
        bus.busy = 1'b1;
        tick();
        bus.busy = 1'b0; bus.idle_thresh = 8'd0;
        gated_seen = 0;
        repeat (100) begin
            tick();
            if (bus.gated) gated_seen++;
        end
        chk("thr_zero.never_gates", gated_seen, 0);

        // Threshold 0 leaves an existing GATED state alone.
        bus.idle_thresh = 8'd1;
        tick();
        bus.idle_thresh = 8'd0;
        repeat (5) tick();
        chk("thr_zero.stays_gated", bus.gated, 1);

        // Counter saturation and clear.
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        repeat (STAT_MAX + 3) tick();
        chk("stat.saturate", bus.gated_cycles, STAT_MAX);
        bus.stat_clr = 1'b1;
        tick();
        chk("stat.clear", bus.gated_cycles, 0);
        bus.stat_clr = 1'b0;

        async_reset("rst_gated");

        bus.idle_thresh = 8'd2;
        repeat (2) tick();
        chk("rst_wake.pre_gated", bus.gated, 1);
        bus.busy = 1'b1;
        tick();
        bus.busy = 1'b0;
        async_reset("rst_wake");
        repeat (2) tick();
        chk("rst_wake.regates", bus.gated, 1);

        // Randomised traffic with a well-behaved four-phase requester.
        for (int c = 0; c < 3000; c++) begin
            bus.busy     = ($urandom_range(0, 9) == 0);
            bus.test_en  = ($urandom_range(0, 15) == 0);
            bus.stat_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) bus.idle_thresh = IDLE_W'($urandom_range(0, 6));
            if (!bus.wake_req && !bus.wake_ack && $urandom_range(0, 29) == 0) bus.wake_req = 1'b1;
            else if (bus.wake_req && bus.wake_ack) bus.wake_req = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
